// File: rtl/psubsb_seq_if.sv
// psubsb_seq_if: handshake and operand/result bundle for psubsb_seq.
// master drives start/A/B; slave returns busy/done/RES/ovf.
interface psubsb_seq_if #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
);
    localparam int NLANES = WIDTH / LANE;

    logic              start;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  RES;
    logic [NLANES-1:0] ovf;

    modport master (
        output start, A, B,
        input  busy, done, RES, ovf
    );

    modport slave (
        input  start, A, B,
        output busy, done, RES, ovf
    );
endinterface

// File: rtl/psubsb_seq.sv
// psubsb_seq: nibble-serial saturating parallel subtract, one lane per clock.
// Ports: clk, rst (sync, active high), bus (slave: start/A/B in; busy/done/RES/ovf out).
module psubsb_seq #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic         clk,
    input  logic         rst,
    psubsb_seq_if.slave  bus
);
    localparam int NLANES = WIDTH / LANE;
    localparam int CW     = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NLANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [NLANES-1:0] shovf_q, shovf_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [NLANES-1:0] ovf_q, ovf_d;

    logic [LANE-1:0]   la, lb, ld, lane_r;
    logic              lane_o;

    // Current lane: borrow stays inside the lane, clamp on signed overflow.
    always_comb begin
        la     = a_q[cnt_q*LANE +: LANE];
        lb     = b_q[cnt_q*LANE +: LANE];
        ld     = la + ~lb + LANE'(1);
        lane_o = (la[LANE-1] ^ lb[LANE-1]) & (ld[LANE-1] ^ la[LANE-1]);
        if (!lane_o)
            lane_r = ld;
        else if (la[LANE-1])
            lane_r = {1'b1, {(LANE-1){1'b0}}};
        else
            lane_r = {1'b0, {(LANE-1){1'b1}}};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        shovf_d = shovf_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sh_d    = '0;
                    shovf_d = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sh_d[cnt_q*LANE +: LANE] = lane_r;
                shovf_d[cnt_q]           = lane_o;
                cnt_d                    = cnt_q + CW'(1);
                // Publish only once every lane is in the shadow copy.
                if (cnt_q == LAST) begin
                    res_d   = sh_d;
                    ovf_d   = shovf_d;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            shovf_q <= '0;
            res_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            shovf_q <= shovf_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.RES  = res_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_psubsb_seq.sv
// tb_psubsb_seq: table vectors, handshake/reset sequences and random ops
// checked against an integer-arithmetic model of saturating subtract.
module tb_psubsb_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psubsb_seq_if #(.WIDTH(16), .LANE(4)) bus ();

    psubsb_seq #(.WIDTH(16), .LANE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] prev_res = '0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Saturating lane subtract from plain signed integer arithmetic.
    function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic [3:0] o);
        int sa, sb, d;
        logic [31:0] t;
        r = '0;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            sa = int'($signed(a[i*4 +: 4]));
            sb = int'($signed(b[i*4 +: 4]));
            d  = sa - sb;
            if (d > 7) begin
                d = 7;
                o[i] = 1'b1;
            end else if (d < -8) begin
                d = -8;
                o[i] = 1'b1;
            end
            t = d;
            r[i*4 +: 4] = t[3:0];
        end
    endfunction

    // Issue one op from the current cycle; return at the done cycle (+1ns).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [3:0] o);
        int  n;
        bit  busy_ok, stable_ok;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        n = 1;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        while (!bus.done && n < 20) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.RES !== prev_res) stable_ok = 1'b0;
            tick();
            n++;
        end
        chk("done_latency", n, 5);
        chk("busy_run", {31'd0, busy_ok}, 1);
        chk("res_stable", {31'd0, stable_ok}, 1);
        chk("busy_at_done", {31'd0, bus.busy}, 0);
        r = bus.RES;
        o = bus.ovf;
        prev_res = bus.RES;
    endtask

    initial begin
        vec_t tbl[$];
        logic [15:0] r, er, a, b;
        logic [3:0]  o, eo;
        bit          saw_done;

        tbl.push_back('{16'h1234, 16'h1111, 16'h0123, 4'b0000});
        tbl.push_back('{16'h8A73, 16'h1CF2, 16'h8E71, 4'b1010});
        tbl.push_back('{16'h0000, 16'h8888, 16'h7777, 4'b1111});
        tbl.push_back('{16'h8888, 16'h0000, 16'h8888, 4'b0000});
        tbl.push_back('{16'h5A5A, 16'h5A5A, 16'h0000, 4'b0000});
        tbl.push_back('{16'h7808, 16'hF180, 16'h7878, 4'b1110});

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst       = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_res", {16'd0, bus.RES}, 0);
        chk("rst_ovf", {28'd0, bus.ovf}, 0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, r, o);
            chk($sformatf("tbl%0d_res", i), {16'd0, r}, {16'd0, tbl[i].res});
            chk($sformatf("tbl%0d_ovf", i), {28'd0, o}, {28'd0, tbl[i].ovf});
        end
        tick();

        // Start during busy is ignored; then back-to-back start in DONE.
        bus.start = 1'b1;
        bus.A = 16'h1234;
        bus.B = 16'h1111;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.A = 16'hFFFF;
        bus.B = 16'h0001;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("hs_done", {31'd0, bus.done}, 1);
        chk("hs_res", {16'd0, bus.RES}, 32'h0123);
        bus.start = 1'b1;
        bus.A = 16'h0000;
        bus.B = 16'h8888;
        tick();
        bus.start = 1'b0;
        chk("b2b_busy", {31'd0, bus.busy}, 1);
        tick();
        tick();
        tick();
        tick();
        chk("b2b_done", {31'd0, bus.done}, 1);
        chk("b2b_res", {16'd0, bus.RES}, 32'h7777);
        chk("b2b_ovf", {28'd0, bus.ovf}, 32'hF);
        tick();

        // Reset in the middle of a run discards the operation.
        bus.start = 1'b1;
        bus.A = 16'h1234;
        bus.B = 16'h1111;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, bus.busy}, 0);
        chk("mid_rst_done", {31'd0, bus.done}, 0);
        chk("mid_rst_res", {16'd0, bus.RES}, 0);
        chk("mid_rst_ovf", {28'd0, bus.ovf}, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        chk("mid_rst_no_done", {31'd0, saw_done}, 0);
        prev_res = '0;
        do_op(16'h8A73, 16'h1CF2, r, o);
        chk("post_rst_res", {16'd0, r}, 32'h8E71);
        chk("post_rst_ovf", {28'd0, o}, 32'hA);
        tick();

        // Reset beats a simultaneous start.
        rst = 1'b1;
        bus.start = 1'b1;
        bus.A = 16'h1234;
        bus.B = 16'h1111;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", {31'd0, bus.busy}, 0);
        chk("rst_start_res", {16'd0, bus.RES}, 0);
        prev_res = '0;
        tick();

        for (int k = 0; k < 200; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            ref_sub(a, b, er, eo);
            do_op(a, b, r, o);
            chk("rnd_res", {16'd0, r}, {16'd0, er});
            chk("rnd_ovf", {28'd0, o}, {28'd0, eo});
            if (k % 3 == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/psubsb_seq.md
Name: psubsb_seq

Overview:
- Nibble-serial saturating parallel subtract (PSUBSB), the inverse-direction companion to the parallel saturating add unit.
- Computes four independent signed 4-bit lanes, RES[i] = sat(A[i] − B[i]), processing one lane per clock.
- Lives in the execute stage as a multi-cycle functional unit with a start/busy/done handshake.
- Also reports a per-lane saturation flag, so the surrounding datapath and bench can check clamping.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of LANE.
- LANE, 4, lane width in bits (signed two's complement).
- NLANES, WIDTH/LANE, number of lanes; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- A  input  WIDTH  minuend, captured on accepted start.
- B  input  WIDTH  subtrahend, captured on accepted start.
- busy  output  1  high while lanes are being computed.
- done  output  1  one-cycle pulse; RES/ovf valid and updated.
- RES  output  WIDTH  packed saturated differences, lane 0 in bits [LANE-1:0].
- ovf  output  NLANES  per-lane saturation flags for the last operation.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, RES=0, ovf=0, lane counter=0, operand registers=0.
  - Applies from any state, including mid-RUN; the in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 → capture A,B; clear the shadow result; counter=0; go to RUN.
  - RUN: busy=1, done=0. Each cycle computes the lane at the counter index into the shadow result/flags; counter increments.
  - After lane NLANES-1: copy shadow to RES and ovf, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 here is accepted (back-to-back, same as IDLE → RUN); otherwise go to IDLE.
- Start while busy=1 is ignored; the captured operands are unaffected by A/B changes after capture.
- Latency:
  - start high in cycle 0 → busy high cycles 1..NLANES (1..4).
  - done high in cycle NLANES+1 (cycle 5).
  - RES/ovf change only at the edge entering DONE. Throughput is one op per NLANES+1 cycles.
- RES and ovf hold their values until the next DONE or reset; intermediate lanes are never visible on RES.
- Lane arithmetic (per lane, signed 4-bit):
  - d = a − b, computed as a + ~b + 1, keeping the low LANE bits.
  - Overflow when sign(a) ≠ sign(b) and sign(d) ≠ sign(a).
  - On overflow: lane = 4'h7 if a is non-negative (a[3]=0), 4'h8 if a is negative; ovf[i]=1.
  - Otherwise lane = d; ovf[i]=0.
  - Lanes are fully independent; no borrow crosses a lane boundary.
- Boundary cases:
  - −8 − 0 = 8 with no overflow.
  - 0 − (−8) saturates to 7.
  - −8 − 1 saturates to 8.
  - 7 − (−1) saturates to 7.
  - x − x = 0.
- Reset and start in the same cycle: reset wins.

Test Plan:
- After reset, start=1 for one cycle with A=16'h1234, B=16'h1111 → busy high 4 cycles; done pulses in cycle 5 with RES=16'h0123, ovf=4'b0000.
- Mixed-lane check: A=16'h8A73, B=16'h1CF2 → RES=16'h8E71, ovf=4'b1010.
  - Lane3 (−8−1) clamps to 8; lane1 (7−(−1)) clamps to 7.
- All-lane saturation and its non-overflow counterpart:
  - A=16'h0000, B=16'h8888 → RES=16'h7777, ovf=4'b1111.
  - A=16'h8888, B=16'h0000 → RES=16'h8888, ovf=4'b0000.
- Busy/back-to-back handshake:
  - Start with A=16'h1234, B=16'h1111; pulse start with new operands in cycle 2 → ignored; done in cycle 5 with RES=16'h0123.
  - Hold start=1 in the DONE cycle with A=16'h0000, B=16'h8888 → busy again next cycle; second done 5 cycles later with RES=16'h7777.
- Reset mid-operation: assert rst in cycle 3 of a RUN → next cycle busy=0, done=0, RES=0, ovf=0; no done pulse follows.
  - A fresh start afterwards completes normally.
- Randomized: 200 random A/B pairs checked lane-by-lane against a reference model of the saturating subtract; RES must stay stable between done pulses.
